// File: rtl/axi_rd_arb_pkg.sv
// Shared constants for the bridge read arbiter: port ids and read request types.
package axi_rd_arb_pkg;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [1:0] RD_TYPE_UNCACHE = 2'b00;
    localparam logic [1:0] RD_TYPE_LINE    = 2'b01;
    localparam logic [1:0] RD_TYPE_DLINE   = 2'b10;

endpackage

// File: rtl/axi_rd_owner_fifo.sv
// In-order record of which port owns each accepted-but-incomplete bridge read.
// Push is ignored when full and pop is ignored when empty.
module axi_rd_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates icache (port 0) and dcache prefetcher (port 1) onto the bridge read port and
// steers returns back to the owner. Define RD_ARB_DCACHE_PRIO_EN for fixed dcache priority.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_rd_req,
    input  logic [1:0]   i_rd_type,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic         i_ret_half,
    input  logic         d_rd_req,
    input  logic [1:0]   d_rd_type,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic         d_ret_half,
    output logic [255:0] ret_data,
    output logic         axi_rd_req,
    output logic [1:0]   axi_rd_type,
    output logic [31:0]  axi_rd_addr,
    input  logic         axi_rd_rdy,
    input  logic         axi_ret_valid,
    input  logic         axi_ret_half,
    input  logic [255:0] axi_ret_data,
    output logic         err_orphan_ret
);

    localparam int CNT_W = $clog2(OUTSTANDING) + 1;

    logic             lock_q, lock_d;
    logic             lock_port_q, lock_port_d;
    logic             err_q, err_d;
    logic             contend_winner;
    logic             grant;
    logic             gnt_req;
    logic             accept;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             owner_valid;
    logic             ret_pop;

`ifdef RD_ARB_DCACHE_PRIO_EN
    assign contend_winner = PORT_D;
`else
    logic rr_q, rr_d;

    assign contend_winner = rr_q;

    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = ~grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= PORT_I;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // A stalled request pins the grant so type/addr cannot change under the bridge.
    always_comb begin
        grant = PORT_I;
        if (lock_q) begin
            grant = lock_port_q;
        end else if (i_rd_req && d_rd_req) begin
            grant = contend_winner;
        end else if (d_rd_req) begin
            grant = PORT_D;
        end
    end

    assign gnt_req     = (grant == PORT_D) ? d_rd_req : i_rd_req;
    assign axi_rd_req  = gnt_req && !fifo_full;
    assign accept      = axi_rd_req && axi_rd_rdy;
    assign i_rd_rdy    = accept && (grant == PORT_I);
    assign d_rd_rdy    = accept && (grant == PORT_D);
    assign axi_rd_type = !gnt_req ? 2'b00 : ((grant == PORT_D) ? d_rd_type : i_rd_type);
    assign axi_rd_addr = !gnt_req ? 32'd0 : ((grant == PORT_D) ? d_rd_addr : i_rd_addr);

    assign owner_valid = !fifo_empty;
    assign ret_pop     = axi_ret_valid && owner_valid;
    assign i_ret_valid = ret_pop && (fifo_head == PORT_I);
    assign d_ret_valid = ret_pop && (fifo_head == PORT_D);
    assign i_ret_half  = axi_ret_half && owner_valid && (fifo_head == PORT_I);
    assign d_ret_half  = axi_ret_half && owner_valid && (fifo_head == PORT_D);
    assign ret_data    = axi_ret_data;

    assign err_orphan_ret = err_q;

    always_comb begin
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        err_d       = err_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if (axi_rd_req && !axi_rd_rdy) begin
            lock_d      = 1'b1;
            lock_port_d = grant;
        end else if (lock_q && !gnt_req) begin
            lock_d = 1'b0;
        end
        if ((axi_ret_valid || axi_ret_half) && (fifo_count == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q      <= 1'b0;
            lock_port_q <= PORT_I;
            err_q       <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            err_q       <= err_d;
        end
    end

    axi_rd_owner_fifo #(
        .DEPTH (OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_owner_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_id (grant),
        .pop     (ret_pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_axi_rd_arbiter;

    localparam int OUTSTANDING = 2;
`ifdef RD_ARB_DCACHE_PRIO_EN
    localparam bit PRIO_D = 1'b1;
`else
    localparam bit PRIO_D = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         i_rd_req;
    logic [1:0]   i_rd_type;
    logic [31:0]  i_rd_addr;
    logic         i_rd_rdy;
    logic         i_ret_valid;
    logic         i_ret_half;
    logic         d_rd_req;
    logic [1:0]   d_rd_type;
    logic [31:0]  d_rd_addr;
    logic         d_rd_rdy;
    logic         d_ret_valid;
    logic         d_ret_half;
    logic [255:0] ret_data;
    logic         axi_rd_req;
    logic [1:0]   axi_rd_type;
    logic [31:0]  axi_rd_addr;
    logic         axi_rd_rdy;
    logic         axi_ret_valid;
    logic         axi_ret_half;
    logic [255:0] axi_ret_data;
    logic         err_orphan_ret;

    axi_rd_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_rd_req       (i_rd_req),
        .i_rd_type      (i_rd_type),
        .i_rd_addr      (i_rd_addr),
        .i_rd_rdy       (i_rd_rdy),
        .i_ret_valid    (i_ret_valid),
        .i_ret_half     (i_ret_half),
        .d_rd_req       (d_rd_req),
        .d_rd_type      (d_rd_type),
        .d_rd_addr      (d_rd_addr),
        .d_rd_rdy       (d_rd_rdy),
        .d_ret_valid    (d_ret_valid),
        .d_ret_half     (d_ret_half),
        .ret_data       (ret_data),
        .axi_rd_req     (axi_rd_req),
        .axi_rd_type    (axi_rd_type),
        .axi_rd_addr    (axi_rd_addr),
        .axi_rd_rdy     (axi_rd_rdy),
        .axi_ret_valid  (axi_ret_valid),
        .axi_ret_half   (axi_ret_half),
        .axi_ret_data   (axi_ret_data),
        .err_orphan_ret (err_orphan_ret)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: owners of outstanding reads in order, pending stalled port, fairness
    logic [0:0] exp_q[$];
    bit         m_lock;
    bit         m_lock_port;
    bit         m_rr;
    bit         m_err;

    int checks;
    int failures;

    // Values sampled in the last cycle, for directed literal checks
    logic        o_i_rdy, o_d_rdy, o_i_rv, o_i_rh, o_d_rv, o_d_rh, o_req, o_err;
    logic [31:0] o_addr;
    bit          acc_i, acc_d;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_lock      = 1'b0;
        m_lock_port = 1'b0;
        m_rr        = 1'b0;
        m_err       = 1'b0;
    endtask

    // One clock: predict, compare mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit          full, empty, g, greq, acc, hd, pop, evt;
        logic [1:0]  e_type;
        logic [31:0] e_addr;
        full  = (exp_q.size() == OUTSTANDING);
        empty = (exp_q.size() == 0);
        if (m_lock)                     g = m_lock_port;
        else if (i_rd_req && d_rd_req)  g = PRIO_D ? 1'b1 : m_rr;
        else                            g = d_rd_req;
        greq   = g ? d_rd_req : i_rd_req;
        acc    = greq && !full && axi_rd_rdy;
        hd     = empty ? 1'b0 : exp_q[0];
        pop    = axi_ret_valid && !empty;
        evt    = (axi_ret_valid || axi_ret_half) && empty;
        e_type = !greq ? 2'b00 : (g ? d_rd_type : i_rd_type);
        e_addr = !greq ? 32'd0 : (g ? d_rd_addr : i_rd_addr);
        #3;
        chk("axi_rd_req", axi_rd_req, greq && !full);
        chk("axi_rd_type", axi_rd_type, e_type);
        chk("axi_rd_addr", axi_rd_addr, e_addr);
        chk("i_rd_rdy", i_rd_rdy, acc && !g);
        chk("d_rd_rdy", d_rd_rdy, acc && g);
        chk("i_ret_valid", i_ret_valid, pop && !hd);
        chk("d_ret_valid", d_ret_valid, pop && hd);
        chk("i_ret_half", i_ret_half, axi_ret_half && !empty && !hd);
        chk("d_ret_half", d_ret_half, axi_ret_half && !empty && hd);
        chk("ret_data", ret_data, axi_ret_data);
        chk("err_orphan_ret", err_orphan_ret, m_err);
        o_i_rdy = i_rd_rdy;  o_d_rdy = d_rd_rdy;
        o_i_rv  = i_ret_valid; o_i_rh = i_ret_half;
        o_d_rv  = d_ret_valid; o_d_rh = d_ret_half;
        o_req   = axi_rd_req; o_addr = axi_rd_addr; o_err = err_orphan_ret;
        acc_i   = acc && !g;
        acc_d   = acc && g;
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(g);
        if (evt) m_err = 1'b1;
        if (acc) begin
            m_lock = 1'b0;
            m_rr   = !g;
        end else if (greq && !full && !axi_rd_rdy) begin
            m_lock      = 1'b1;
            m_lock_port = g;
        end else if (m_lock && !greq) begin
            m_lock = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        axi_rd_rdy = 0; axi_ret_valid = 0; axi_ret_half = 0; axi_ret_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #3;
        chk("rst_outputs", {i_rd_rdy, i_ret_valid, i_ret_half, d_rd_rdy, d_ret_valid, d_ret_half,
                            axi_rd_req, axi_rd_type, axi_rd_addr, err_orphan_ret}, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
        chk("post_rst_outputs", {o_i_rdy, o_d_rdy, o_i_rv, o_i_rh, o_d_rv, o_d_rh, o_req,
                                 o_addr, o_err}, '0);
    endtask

    initial begin
        logic [1:0] exp_g;
        checks   = 0;
        failures = 0;

        // Single request and return
        do_reset();
        i_rd_req = 1; i_rd_type = 2'b01; i_rd_addr = 32'h1FC0_0000; axi_rd_rdy = 1;
        cycle();
        chk("t1_i_rdy", o_i_rdy, 1'b1);
        chk("t1_addr", o_addr, 32'h1FC0_0000);
        i_rd_req = 0;
        cycle();
        axi_ret_valid = 1; axi_ret_data = {8{$urandom}};
        cycle();
        chk("t1_i_ret_valid", o_i_rv, 1'b1);
        chk("t1_d_ret_valid", o_d_rv, 1'b0);
        axi_ret_valid = 0;

        // Contention: four back-to-back accepts
        do_reset();
        i_rd_req = 1; i_rd_addr = 32'h0000_1000;
        d_rd_req = 1; d_rd_addr = 32'h0000_2000; d_rd_type = 2'b01;
        axi_rd_rdy = 1;
        for (int k = 0; k < 4; k++) begin
            axi_ret_valid = (k > 0);
            cycle();
            exp_g = PRIO_D ? 2'b01 : ((k % 2 == 0) ? 2'b10 : 2'b01);
            chk("t2_grant", {o_i_rdy, o_d_rdy}, exp_g);
        end

        // Lock: stalled dcache request holds the bus
        do_reset();
        d_rd_req = 1; d_rd_type = 2'b01; d_rd_addr = 32'h8000_0040; axi_rd_rdy = 0;
        cycle();
        chk("t3_addr", o_addr, 32'h8000_0040);
        i_rd_req = 1; i_rd_addr = 32'h0000_3000;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t3_addr_held", o_addr, 32'h8000_0040);
            chk("t3_no_rdy", {o_i_rdy, o_d_rdy}, 2'b00);
        end
        axi_rd_rdy = 1;
        cycle();
        chk("t3_d_accept", o_d_rdy, 1'b1);
        chk("t3_d_addr", o_addr, 32'h8000_0040);
        d_rd_req = 0;
        cycle();
        chk("t3_i_next", o_i_rdy, 1'b1);
        chk("t3_i_addr", o_addr, 32'h0000_3000);
        i_rd_req = 0;

        // Ordering of returns
        do_reset();
        d_rd_req = 1; d_rd_type = 2'b10; d_rd_addr = 32'h0000_4000; axi_rd_rdy = 1;
        cycle();
        d_rd_req = 0; i_rd_req = 1; i_rd_type = 2'b00; i_rd_addr = 32'h0000_5000;
        cycle();
        i_rd_req = 0; axi_ret_half = 1;
        cycle();
        chk("t4_half", {o_d_rh, o_i_rh}, 2'b10);
        chk("t4_half_novalid", {o_d_rv, o_i_rv}, 2'b00);
        axi_ret_half = 0; axi_ret_valid = 1;
        cycle();
        chk("t4_valid1", {o_d_rv, o_i_rv}, 2'b10);
        cycle();
        chk("t4_valid2", {o_d_rv, o_i_rv}, 2'b01);
        axi_ret_valid = 0;

        // Full FIFO blocks, pop frees a slot for the next cycle
        do_reset();
        i_rd_req = 1; i_rd_type = 2'b01; i_rd_addr = 32'h0000_6000; axi_rd_rdy = 1;
        cycle();
        cycle();
        i_rd_req = 0; d_rd_req = 1; d_rd_addr = 32'h0000_7000;
        cycle();
        chk("t5_full_req", o_req, 1'b0);
        chk("t5_full_rdy", o_d_rdy, 1'b0);
        axi_ret_valid = 1;
        cycle();
        chk("t5_pop_req", o_req, 1'b0);
        chk("t5_pop_iv", o_i_rv, 1'b1);
        axi_ret_valid = 0;
        cycle();
        chk("t5_third", o_d_rdy, 1'b1);
        d_rd_req = 0;

        // Reset with two outstanding, then a stale return
        chk("t6_model_outstanding", exp_q.size(), 2);
        do_reset();
        axi_ret_valid = 1;
        cycle();
        chk("t6_no_strobe", {o_i_rv, o_d_rv}, 2'b00);
        axi_ret_valid = 0;
        cycle();
        chk("t6_err", o_err, 1'b1);
        cycle();
        chk("t6_err_sticky", o_err, 1'b1);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (i_rd_req) begin
                if (acc_i) begin
                    i_rd_req  = $urandom_range(0, 1);
                    i_rd_type = 2'($urandom_range(0, 2));
                    i_rd_addr = $urandom;
                end else if ($urandom_range(0, 7) == 0) begin
                    i_rd_req = 0;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                i_rd_req  = 1;
                i_rd_type = 2'($urandom_range(0, 2));
                i_rd_addr = $urandom;
            end
            if (d_rd_req) begin
                if (acc_d) begin
                    d_rd_req  = $urandom_range(0, 1);
                    d_rd_type = 2'($urandom_range(0, 2));
                    d_rd_addr = $urandom;
                end else if ($urandom_range(0, 7) == 0) begin
                    d_rd_req = 0;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                d_rd_req  = 1;
                d_rd_type = 2'($urandom_range(0, 2));
                d_rd_addr = $urandom;
            end
            axi_rd_rdy    = ($urandom_range(0, 9) < 6);
            axi_ret_valid = (exp_q.size() > 0) && ($urandom_range(0, 9) < 3);
            axi_ret_half  = (exp_q.size() > 0) && !axi_ret_valid && ($urandom_range(0, 9) < 2);
            axi_ret_data  = {8{$urandom}};
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
